adder_tree_psum_accumulator: RTL

Downstream stage for the 2-stage 4-bit adder tree. It consumes the tree's registered 8-bit partial sums and accumulates NUM_TERMS consecutive accepted sums into one wider result. Completed results are presented on a valid/ready output handshake, with optional saturation and an overflow flag. The block applies backpressure to the tree-side producer while a completed result has not been taken.

---
 rtl/adder_tree_psum_accumulator_if.sv | 26 ++
 rtl/adder_tree_psum_accumulator.sv | 122 ++++++++++++
 2 files changed

// File: rtl/adder_tree_psum_accumulator_if.sv
// Handshake bundle between the adder tree, the partial-sum accumulator and its consumer.
// The master side drives terms and takes results; the slave side is the accumulator.
interface adder_tree_psum_accumulator_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16
) ();
    logic [IN_W-1:0]  sum_in;
    logic             sum_valid;
    logic             in_ready;
    logic             clear;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             overflow;
    logic [7:0]       term_count;

    modport master (
        output sum_in, sum_valid, clear, acc_ready,
        input  in_ready, acc_out, acc_valid, overflow, term_count
    );

    modport slave (
        input  sum_in, sum_valid, clear, acc_ready,
        output in_ready, acc_out, acc_valid, overflow, term_count
    );
endinterface

// File: rtl/adder_tree_psum_accumulator.sv
// Accumulates NUM_TERMS accepted partial sums from the adder tree into one wider result,
// with optional saturation, a sticky overflow flag and a valid/ready result handshake.
module adder_tree_psum_accumulator #(
    parameter int IN_W      = 8,
    parameter int ACC_W     = 16,
    parameter int NUM_TERMS = 4,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    adder_tree_psum_accumulator_if.slave  bus
);

    localparam logic [7:0]       LAST_IDX = 8'(NUM_TERMS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    logic [ACC_W-1:0] acc_r;
    logic             sticky_r;
    logic [7:0]       term_count_r;
    logic [ACC_W-1:0] acc_out_r;
    logic             overflow_r;
    logic             acc_valid_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             first_s;
    logic             last_s;
    logic [ACC_W:0]   wide_sum_s;
    logic             carry_s;
    logic [ACC_W-1:0] sum_val_s;
    logic             sticky_next_s;

    logic [ACC_W-1:0] acc_d_s;
    logic             sticky_d_s;
    logic [7:0]       term_count_d_s;
    logic [ACC_W-1:0] acc_out_d_s;
    logic             overflow_d_s;
    logic             acc_valid_d_s;

    // Handshake qualification and the (ACC_W+1)-bit add of the current term.
    always_comb begin
        in_ready_s = !bus.clear && (!acc_valid_r || bus.acc_ready);
        accept_s   = bus.sum_valid && in_ready_s;
        first_s    = (term_count_r == 8'd0);
        last_s     = (term_count_r == LAST_IDX);
        // The first term of a group starts from zero, so stale accumulator state never leaks in.
        wide_sum_s = {1'b0, (first_s ? ACC_ZERO : acc_r)}
                   + {{(ACC_W + 1 - IN_W){1'b0}}, bus.sum_in};
        carry_s    = wide_sum_s[ACC_W];
        if (carry_s && SATURATE) begin
            sum_val_s = ACC_MAX;
        end else begin
            sum_val_s = wide_sum_s[ACC_W-1:0];
        end
        sticky_next_s = (!first_s && sticky_r) || carry_s;
    end

    // Next-state selection for accumulator, counter and presented result.
    always_comb begin
        acc_d_s        = acc_r;
        sticky_d_s     = sticky_r;
        term_count_d_s = term_count_r;
        acc_out_d_s    = acc_out_r;
        overflow_d_s   = overflow_r;
        acc_valid_d_s  = acc_valid_r;

        if (acc_valid_r && bus.acc_ready) begin
            acc_valid_d_s = 1'b0;
        end else begin
            acc_valid_d_s = acc_valid_r;
        end

        if (bus.clear) begin
            acc_d_s        = ACC_ZERO;
            sticky_d_s     = 1'b0;
            term_count_d_s = 8'd0;
        end else if (accept_s) begin
            acc_d_s    = sum_val_s;
            sticky_d_s = sticky_next_s;
            // A completing term overrides the handoff so NUM_TERMS=1 can stream back-to-back.
            if (last_s) begin
                term_count_d_s = 8'd0;
                acc_out_d_s    = sum_val_s;
                overflow_d_s   = sticky_next_s;
                acc_valid_d_s  = 1'b1;
            end else begin
                term_count_d_s = term_count_r + 8'd1;
            end
        end else begin
            acc_d_s        = acc_r;
            sticky_d_s     = sticky_r;
            term_count_d_s = term_count_r;
        end
    end

    // State registers; reset discards any partial group and held result immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r        <= ACC_ZERO;
            sticky_r     <= 1'b0;
            term_count_r <= 8'd0;
            acc_out_r    <= ACC_ZERO;
            overflow_r   <= 1'b0;
            acc_valid_r  <= 1'b0;
        end else begin
            acc_r        <= acc_d_s;
            sticky_r     <= sticky_d_s;
            term_count_r <= term_count_d_s;
            acc_out_r    <= acc_out_d_s;
            overflow_r   <= overflow_d_s;
            acc_valid_r  <= acc_valid_d_s;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.acc_out    = acc_out_r;
    assign bus.acc_valid  = acc_valid_r;
    assign bus.overflow   = overflow_r;
    assign bus.term_count = term_count_r;

endmodule
